seq_player: RTL and testbench
=============================

Name: seq_player

Overview:
- Downstream consumer of the permutation generator's 64-bit seq_all word: 16 nibbles, element k = seq_all[4k+3:4k].
- On a load strobe, captures one word and plays its elements out one nibble at a time over a valid/ready stream, index 0 through 15.
- Supports optional inter-element gap and looping, and reports completion.
- Sits between the combinational permutation generator and the display/playback logic.

Parameters:
- STEP_GAP, 0: idle cycles forced between an accepted element and the next valid element (0..255).
- LOOP, 0: 1 = restart at element 0 after element 15; 0 = stop after element 15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- seq_all  input  64  permutation word; 16 nibbles, element k in bits [4k+3:4k].
- load  input  1  capture seq_all and start playback; honoured only in IDLE.
- abort  input  1  synchronous stop; returns to IDLE.
- out_data  output  4  current element.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data.
- out_last  output  1  high with out_valid when the index is 15.
- busy  output  1  high in PLAY or GAP.
- done  output  1  one-cycle pulse after element 15 is accepted.
- pass_cnt  output  8  completed passes; saturates at 255; cleared on an accepted load.
- perm_err  output  1  invalid-permutation flag (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; shadow register 0; index 0; gap counter 0; out_data 0, out_valid 0, out_last 0, busy 0, done 0, pass_cnt 0, perm_err 0.
- Handshake: a transfer occurs when out_valid and out_ready are both high on a clock edge.
  - While out_valid is high, out_data and out_last hold stable until the transfer.
  - out_ready is ignored when out_valid is low.
- States: IDLE, PLAY, GAP.
- IDLE:
  - load=1 and abort=0 at edge t: shadow <= seq_all, index <= 0, pass_cnt <= 0, go to PLAY.
  - out_valid=1 from cycle t+1 with out_data = element 0. Latency from load to first valid is 1 cycle.
- PLAY, transfer at index i<15:
  - If STEP_GAP=0: index <= i+1, stay in PLAY, out_valid stays high. Back-to-back transfers run at 1 element per cycle.
  - If STEP_GAP>0: out_valid <= 0, go to GAP, gap counter <= STEP_GAP.
- GAP: counter decrements each cycle; when it reaches 0, index <= i+1, go to PLAY, out_valid=1. Exactly STEP_GAP cycles with out_valid low.
- Transfer at index 15:
  - done pulses in the next cycle; pass_cnt increments, saturating.
  - LOOP=0: go to IDLE, out_valid <= 0, busy <= 0.
  - LOOP=1: index wraps to 0, then the same PLAY/GAP rule as i<15 applies.
- load while busy is ignored; the shadow register is not updated mid-pass.
- abort=1 in any state: next cycle IDLE, out_valid 0, busy 0, index 0, no done pulse, pass_cnt held.
  - abort has priority over load and over a same-cycle transfer. A transfer in the abort cycle counts toward the consumer only; no index advance is visible afterward.
- out_last = out_valid and (index == 15).
- Reset asserted mid-pass: all state clears immediately, with no done pulse.

Optional Feature:
- Macro: SEQ_PLAYER_PERM_CHECK_EN.
- With the macro:
  - On a load in IDLE, a 16-bit seen-mask checks that all 16 nibbles of seq_all are distinct.
  - If they are not, the load is rejected: state stays IDLE, the shadow register is unchanged, and perm_err <= 1.
  - perm_err is sticky until the next accepted load or reset.
- Without the macro: no check is performed, every load in IDLE is accepted, and perm_err is tied to 0.

Test Plan:
- STEP_GAP=0, LOOP=0, seq_all=0xFEDCBA9876543210, load, out_ready held 1:
  - out_data 0,1,...,15 on 16 consecutive cycles starting 1 cycle after load.
  - out_last only on 15; done pulse on the cycle after; pass_cnt=1; busy low.
- STEP_GAP=3, seq_all=0x0123456789ABCDEF, out_ready=1: out_data 15,14,...,0, with exactly 3 cycles of out_valid low between elements.
- Backpressure: out_ready low for 5 cycles at element 4 → out_data holds element 4 value stable with out_valid high; resumes on out_ready high.
- LOOP=1, identity word, run 40 transfers:
  - Sequence wraps 15→0; done pulses after transfers 16 and 32; pass_cnt=2.
  - load during playback is ignored and the shadow register is unchanged.
- abort asserted at index 7 together with load and out_ready:
  - Next cycle IDLE, out_valid 0, no done pulse, pass_cnt unchanged.
  - A subsequent load restarts at element 0.
- SEQ_PLAYER_PERM_CHECK_EN, seq_all=0x0000000000000000:
  - load rejected, perm_err=1, out_valid stays 0.
  - A following load of a valid word is accepted and clears perm_err.

Source files
------------

// File: rtl/seq_player_if.sv
// Stream and control bundle for seq_player: permutation word in, nibble stream and status out.
// master = the player, slave = the word source / stream consumer.
interface seq_player_if;
  logic [63:0] seq_all;
  logic        load;
  logic        abort;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [7:0]  pass_cnt;
  logic        perm_err;

  modport master (
    input  seq_all, load, abort, out_ready,
    output out_data, out_valid, out_last, busy, done, pass_cnt, perm_err
  );

  modport slave (
    output seq_all, load, abort, out_ready,
    input  out_data, out_valid, out_last, busy, done, pass_cnt, perm_err
  );
endinterface

// File: rtl/seq_player.sv
// Captures a 64-bit permutation word and streams its 16 nibbles over valid/ready.
// Optional macro SEQ_PLAYER_PERM_CHECK_EN rejects loads whose nibbles are not all distinct.
module seq_player #(
  parameter int STEP_GAP = 0,
  parameter int LOOP     = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  seq_player_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [7:0] GapInit = 8'(STEP_GAP);
  localparam bit         GapEn   = (STEP_GAP != 0);
  localparam bit         LoopEn  = (LOOP != 0);

  state_e      state_q, state_d;
  logic [63:0] shadow_q, shadow_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  gap_q, gap_d;
  logic        done_q, done_d;
  logic [7:0]  pass_q, pass_d;
  logic        valid;
  logic        xfer;
  logic        load_ok;

`ifdef SEQ_PLAYER_PERM_CHECK_EN
  logic [15:0] seen;
  logic        perm_err_q, perm_err_d;

  // A word is a permutation exactly when every nibble value 0..15 shows up.
  always_comb begin
    seen = '0;
    for (int k = 0; k < 16; k++) begin
      seen[bus.seq_all[4*k +: 4]] = 1'b1;
    end
  end

  assign load_ok = bus.load & (&seen);

  always_comb begin
    perm_err_d = perm_err_q;
    if (!bus.abort && (state_q == IDLE) && bus.load) begin
      perm_err_d = ~(&seen);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perm_err_q <= 1'b0;
    end else begin
      perm_err_q <= perm_err_d;
    end
  end

  assign bus.perm_err = perm_err_q;
`else
  assign load_ok      = bus.load;
  assign bus.perm_err = 1'b0;
`endif

  assign valid = (state_q == PLAY);
  assign xfer  = valid & bus.out_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      gap_q    <= '0;
      done_q   <= 1'b0;
      pass_q   <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  // Index advances at the transfer itself; while in GAP the data is masked, so it is never seen early.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    done_d   = 1'b0;
    pass_d   = pass_q;

    if (bus.abort) begin
      state_d = IDLE;
      idx_d   = '0;
      gap_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_ok) begin
            shadow_d = bus.seq_all;
            idx_d    = '0;
            pass_d   = '0;
            state_d  = PLAY;
          end
        end

        PLAY: begin
          if (xfer) begin
            if (idx_q == 4'd15) begin
              done_d = 1'b1;
              pass_d = (pass_q == 8'hFF) ? pass_q : pass_q + 8'd1;
            end
            if ((idx_q == 4'd15) && !LoopEn) begin
              state_d = IDLE;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 4'd1;
              if (GapEn) begin
                state_d = GAP;
                gap_d   = GapInit;
              end
            end
          end
        end

        GAP: begin
          if (gap_q <= 8'd1) begin
            state_d = PLAY;
            gap_d   = '0;
          end else begin
            gap_d = gap_q - 8'd1;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.out_valid = valid;
  assign bus.out_data  = valid ? shadow_q[{idx_q, 2'b00} +: 4] : 4'h0;
  assign bus.out_last  = valid & (idx_q == 4'd15);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.pass_cnt  = pass_q;

endmodule

// File: tb/tb_seq_player.sv
// Scoreboard bench for seq_player: three instances (no gap, gap of 3, looping) share clock and reset.
// Stimulus pushes expected stream entries; a negedge monitor pops and checks every transfer.
module tb_seq_player;

  typedef struct {
    int         dut;
    logic [3:0] data;
    logic       last;
    int         delta;
  } exp_t;

  localparam logic [63:0] IdWord  = 64'hFEDCBA9876543210;
  localparam logic [63:0] RevWord = 64'h0123456789ABCDEF;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   lastCyc[3];
  int   checkCount = 0;
  int   passCount  = 0;
  exp_t expQ[$];

  seq_player_if ifA ();
  seq_player_if ifB ();
  seq_player_if ifC ();

  seq_player #(.STEP_GAP(0), .LOOP(0)) dutA (.clk_i(clk), .rst_ni(rst_n), .bus(ifA));
  seq_player #(.STEP_GAP(3), .LOOP(0)) dutB (.clk_i(clk), .rst_ni(rst_n), .bus(ifB));
  seq_player #(.STEP_GAP(0), .LOOP(1)) dutC (.clk_i(clk), .rst_ni(rst_n), .bus(ifC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checkCount++;
    if (act === req) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [63:0] w, input logic ld,
                               input logic ab, input logic rdy);
    case (id)
      0: begin ifA.seq_all = w; ifA.load = ld; ifA.abort = ab; ifA.out_ready = rdy; end
      1: begin ifB.seq_all = w; ifB.load = ld; ifB.abort = ab; ifB.out_ready = rdy; end
      default: begin ifC.seq_all = w; ifC.load = ld; ifC.abort = ab; ifC.out_ready = rdy; end
    endcase
  endtask

  // Load pulse for one cycle with out_ready high; records the load edge for spacing checks.
  task automatic loadWord(input int id, input logic [63:0] w);
    applyStimulus(id, w, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    lastCyc[id] = cyc;
    applyStimulus(id, w, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic pushRun(input int id, input logic [63:0] w, input int startIdx,
                         input int count, input int firstDelta, input int delta);
    for (int n = 0; n < count; n++) begin
      exp_t e;
      int   idx;
      idx     = (startIdx + n) % 16;
      e.dut   = id;
      e.data  = w[4*idx +: 4];
      e.last  = (idx == 15);
      e.delta = (n == 0) ? firstDelta : delta;
      expQ.push_back(e);
    end
  endtask

  // Called at a negedge when valid and ready are high: the transfer happens at the next edge.
  task automatic monitorXfer(input int id, input logic [3:0] data, input logic last);
    exp_t e;
    int   edgeCyc;
    edgeCyc = cyc + 1;
    if (expQ.size() == 0) begin
      checkCount++;
      $display("[TB] FAIL unexpectedXfer dut%0d: got data %0h, required no transfer", id, data);
    end else begin
      e = expQ.pop_front();
      checkOutput("xferDut", 64'(id), 64'(e.dut));
      checkOutput("xferData", 64'(data), 64'(e.data));
      checkOutput("xferLast", 64'(last), 64'(e.last));
      if (e.delta != 0) begin
        checkOutput("xferSpacing", 64'(edgeCyc - lastCyc[id]), 64'(e.delta));
      end
    end
    lastCyc[id] = edgeCyc;
  endtask

  always @(negedge clk) begin
    if (ifA.out_valid && ifA.out_ready) monitorXfer(0, ifA.out_data, ifA.out_last);
    if (ifB.out_valid && ifB.out_ready) monitorXfer(1, ifB.out_data, ifB.out_last);
    if (ifC.out_valid && ifC.out_ready) monitorXfer(2, ifC.out_data, ifC.out_last);
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 64'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 64'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(2, 64'h0, 1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("rstValid", 64'(ifA.out_valid), 64'h0);
    checkOutput("rstData", 64'(ifA.out_data), 64'h0);
    checkOutput("rstLast", 64'(ifA.out_last), 64'h0);
    checkOutput("rstBusy", 64'(ifA.busy), 64'h0);
    checkOutput("rstDone", 64'(ifA.done), 64'h0);
    checkOutput("rstPass", 64'(ifA.pass_cnt), 64'h0);
    checkOutput("rstPermErr", 64'(ifA.perm_err), 64'h0);
    checkOutput("rstValidB", 64'(ifB.out_valid), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Straight playback, one element per cycle.
    pushRun(0, IdWord, 0, 16, 1, 1);
    loadWord(0, IdWord);
    repeat (16) @(posedge clk);
    @(negedge clk);
    checkOutput("t1Done", 64'(ifA.done), 64'h1);
    checkOutput("t1Pass", 64'(ifA.pass_cnt), 64'h1);
    checkOutput("t1Busy", 64'(ifA.busy), 64'h0);
    checkOutput("t1Valid", 64'(ifA.out_valid), 64'h0);
    @(negedge clk);
    checkOutput("t1DonePulse", 64'(ifA.done), 64'h0);

    // Three idle cycles between elements.
    pushRun(1, RevWord, 0, 16, 1, 4);
    loadWord(1, RevWord);
    repeat (61) @(posedge clk);
    @(negedge clk);
    checkOutput("t2Done", 64'(ifB.done), 64'h1);
    checkOutput("t2Pass", 64'(ifB.pass_cnt), 64'h1);
    checkOutput("t2Busy", 64'(ifB.busy), 64'h0);

    // Backpressure holding element 4 for five cycles.
    pushRun(0, IdWord, 0, 4, 1, 1);
    pushRun(0, IdWord, 4, 1, 6, 1);
    pushRun(0, IdWord, 5, 11, 1, 1);
    loadWord(0, IdWord);
    repeat (4) @(posedge clk);
    #1 applyStimulus(0, IdWord, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t3HoldValid", 64'(ifA.out_valid), 64'h1);
      checkOutput("t3HoldData", 64'(ifA.out_data), 64'h4);
    end
    @(posedge clk);
    #1 applyStimulus(0, IdWord, 1'b0, 1'b0, 1'b1);
    repeat (12) @(posedge clk);
    @(negedge clk);
    checkOutput("t3Done", 64'(ifA.done), 64'h1);
    checkOutput("t3Pass", 64'(ifA.pass_cnt), 64'h1);

    // Looping playback, 40 transfers, with a load mid-pass that must be ignored.
    pushRun(2, IdWord, 0, 40, 1, 1);
    loadWord(2, IdWord);
    repeat (10) @(posedge clk);
    #1 applyStimulus(2, RevWord, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1 applyStimulus(2, IdWord, 1'b0, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("t4NoEarlyDone", 64'(ifC.done), 64'h0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("t4Done1", 64'(ifC.done), 64'h1);
    checkOutput("t4Pass1", 64'(ifC.pass_cnt), 64'h1);
    checkOutput("t4Busy", 64'(ifC.busy), 64'h1);
    repeat (16) @(posedge clk);
    @(negedge clk);
    checkOutput("t4Done2", 64'(ifC.done), 64'h1);
    checkOutput("t4Pass2", 64'(ifC.pass_cnt), 64'h2);
    repeat (8) @(posedge clk);
    #1 applyStimulus(2, IdWord, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t4StallValid", 64'(ifC.out_valid), 64'h1);
    checkOutput("t4StallData", 64'(ifC.out_data), 64'h8);
    checkOutput("t4PassEnd", 64'(ifC.pass_cnt), 64'h2);
    @(posedge clk);
    #1 applyStimulus(2, IdWord, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1 applyStimulus(2, IdWord, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t4AbortValid", 64'(ifC.out_valid), 64'h0);
    checkOutput("t4AbortPass", 64'(ifC.pass_cnt), 64'h2);

    // Abort together with load and a transfer at index 7.
    pushRun(0, IdWord, 0, 8, 1, 1);
    loadWord(0, IdWord);
    repeat (7) @(posedge clk);
    #1 applyStimulus(0, RevWord, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1 applyStimulus(0, IdWord, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t5Valid", 64'(ifA.out_valid), 64'h0);
    checkOutput("t5Busy", 64'(ifA.busy), 64'h0);
    checkOutput("t5Done", 64'(ifA.done), 64'h0);
    checkOutput("t5Pass", 64'(ifA.pass_cnt), 64'h0);
    @(negedge clk);
    checkOutput("t5DoneLater", 64'(ifA.done), 64'h0);
    pushRun(0, IdWord, 0, 16, 1, 1);
    loadWord(0, IdWord);
    repeat (16) @(posedge clk);
    @(negedge clk);
    checkOutput("t5RestartDone", 64'(ifA.done), 64'h1);
    checkOutput("t5RestartPass", 64'(ifA.pass_cnt), 64'h1);

`ifdef SEQ_PLAYER_PERM_CHECK_EN
    applyStimulus(0, 64'h0, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1 applyStimulus(0, 64'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t6RejValid", 64'(ifA.out_valid), 64'h0);
    checkOutput("t6RejBusy", 64'(ifA.busy), 64'h0);
    checkOutput("t6RejErr", 64'(ifA.perm_err), 64'h1);
    checkOutput("t6RejPass", 64'(ifA.pass_cnt), 64'h1);
    @(negedge clk);
    checkOutput("t6ErrSticky", 64'(ifA.perm_err), 64'h1);
    pushRun(0, IdWord, 0, 16, 1, 1);
    loadWord(0, IdWord);
`else
    pushRun(0, 64'h0, 0, 16, 1, 1);
    loadWord(0, 64'h0);
`endif
    @(negedge clk);
    checkOutput("t6ErrClear", 64'(ifA.perm_err), 64'h0);
    checkOutput("t6Valid", 64'(ifA.out_valid), 64'h1);
    repeat (16) @(posedge clk);
    @(negedge clk);
    checkOutput("t6Done", 64'(ifA.done), 64'h1);

    // Looping long enough to push pass_cnt past 255.
    pushRun(2, IdWord, 0, 16 * 256, 1, 1);
    loadWord(2, IdWord);
    repeat (16 * 256) @(posedge clk);
    #1 applyStimulus(2, IdWord, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t7Saturate", 64'(ifC.pass_cnt), 64'hFF);
    checkOutput("t7Done", 64'(ifC.done), 64'h1);

    // Reset in the middle of a pass.
    pushRun(0, IdWord, 0, 5, 1, 1);
    loadWord(0, IdWord);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t8Valid", 64'(ifA.out_valid), 64'h0);
    checkOutput("t8Busy", 64'(ifA.busy), 64'h0);
    checkOutput("t8Data", 64'(ifA.out_data), 64'h0);
    checkOutput("t8Done", 64'(ifA.done), 64'h0);
    checkOutput("t8PassC", 64'(ifC.pass_cnt), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("t8NoDone", 64'(ifA.done), 64'h0);
    checkOutput("queueEmpty", 64'(expQ.size()), 64'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
